btb_predictor: RTL

- Branch target buffer with 2-bit saturating direction counters, located in IF.
- Each cycle it looks up the fetch PC and supplies the prediction and next fetch PC to IF.
- The prediction travels down the pipe and reaches the EX-stage branch/jump resolver as predictedTaken_ex.
- It is trained by that resolver's update_btb_ex, ex_branch_taken and jump_addr_ex outputs, and keeps update/mispredict statistics counters.

---
 rtl/btb_predictor_if.sv | 32 +++
 rtl/btb_predictor.sv | 129 ++++++++++++
 2 files changed

// File: rtl/btb_predictor_if.sv
// Fetch-side lookup and EX-side training bus for the branch target buffer.
interface btb_predictor_if;
  // IF-stage lookup
  logic [31:0] pc_if;
  logic        btb_hit_if;
  logic        predicted_taken_if;
  logic [31:0] predicted_target_if;
  logic [31:0] next_pc_if;
  // EX-stage training
  logic        update_btb_ex;
  logic [31:0] pc_ex;
  logic        ex_branch_taken;
  logic [31:0] jump_addr_ex;
  logic        modify_pc_ex;
  // statistics
  logic [31:0] update_count;
  logic [31:0] mispredict_count;

  // Pipeline side: drives fetch PC and resolver outcomes, consumes predictions.
  modport master (
    output pc_if, update_btb_ex, pc_ex, ex_branch_taken, jump_addr_ex, modify_pc_ex,
    input  btb_hit_if, predicted_taken_if, predicted_target_if, next_pc_if,
           update_count, mispredict_count
  );

  // Predictor side.
  modport slave (
    input  pc_if, update_btb_ex, pc_ex, ex_branch_taken, jump_addr_ex, modify_pc_ex,
    output btb_hit_if, predicted_taken_if, predicted_target_if, next_pc_if,
           update_count, mispredict_count
  );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on pc_if; training from EX lands on the next clk edge,
// so a same-cycle lookup of the trained index still sees the old contents.
module btb_predictor #(
  parameter int ENTRIES    = 16,
  parameter int INDEX_BITS = $clog2(ENTRIES),
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic           clk,
  input  logic           rst,
  btb_predictor_if.slave bus
);

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;
  localparam logic [1:0] CTR_MAX     = 2'b11;
  localparam logic [1:0] CTR_MIN     = 2'b00;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [31:0] upd_cnt_q, upd_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  // Word-aligned PCs: the low two bits never select anything.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.pc_if[1:0], bus.pc_ex[1:0]};

  // ---------------- lookup ----------------
  logic [INDEX_BITS-1:0] l_idx;
  logic [TAG_BITS-1:0]   l_tag;
  logic                  l_hit;

  assign l_idx = bus.pc_if[INDEX_BITS+1:2];
  assign l_tag = bus.pc_if[31:INDEX_BITS+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  // Prediction outputs are fully combinational from pc_if and the array.
  always_comb begin
    bus.btb_hit_if          = l_hit;
    bus.predicted_taken_if  = l_hit && ctr_q[l_idx][1];
    bus.predicted_target_if = l_hit ? target_q[l_idx] : 32'h0;
    bus.next_pc_if          = bus.predicted_taken_if ? bus.predicted_target_if
                                                     : bus.pc_if + 32'd4;
  end

  // ---------------- training ----------------
  logic [INDEX_BITS-1:0] u_idx;
  logic [TAG_BITS-1:0]   u_tag;
  logic                  u_hit;
  logic                  wr_en;
  logic [TAG_BITS-1:0]   tag_d;
  logic [31:0]           target_d;
  logic [1:0]            ctr_d;

  assign u_idx = bus.pc_ex[INDEX_BITS+1:2];
  assign u_tag = bus.pc_ex[31:INDEX_BITS+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // New contents for the trained entry; a not-taken miss leaves the array alone.
  always_comb begin
    wr_en    = 1'b0;
    tag_d    = tag_q[u_idx];
    target_d = target_q[u_idx];
    ctr_d    = ctr_q[u_idx];
    if (bus.update_btb_ex) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (bus.ex_branch_taken) begin
          ctr_d    = (ctr_q[u_idx] == CTR_MAX) ? CTR_MAX : ctr_q[u_idx] + 2'd1;
          target_d = bus.jump_addr_ex;
        end else begin
          ctr_d    = (ctr_q[u_idx] == CTR_MIN) ? CTR_MIN : ctr_q[u_idx] - 2'd1;
        end
      end else if (bus.ex_branch_taken) begin
        // Allocate or evict the alias outright; the old tag is gone.
        wr_en    = 1'b1;
        tag_d    = u_tag;
        target_d = bus.jump_addr_ex;
        ctr_d    = CTR_WEAK_T;
      end
    end
  end

  // Array state; reset wins over a same-edge update, which is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0;
        ctr_q[i]    <= CTR_WEAK_NT;
      end
    end else if (wr_en) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= tag_d;
      target_q[u_idx] <= target_d;
      ctr_q[u_idx]    <= ctr_d;
    end
  end

  // ---------------- statistics ----------------
  // Free-running 32-bit counters that wrap.
  always_comb begin
    upd_cnt_d = upd_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (bus.update_btb_ex) begin
      upd_cnt_d = upd_cnt_q + 32'd1;
      if (bus.modify_pc_ex) mis_cnt_d = mis_cnt_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_cnt_q <= 32'h0;
      mis_cnt_q <= 32'h0;
    end else begin
      upd_cnt_q <= upd_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign bus.update_count     = upd_cnt_q;
  assign bus.mispredict_count = mis_cnt_q;

endmodule
